// File: rtl/redun_mont_pkg.sv
// Shared types for the redun_mont repeated-squaring core and its iteration sequencer.
package redun_mont_pkg;

  localparam int DATA_W = 64;
  localparam int T_LEN  = 16;

  typedef logic [DATA_W-1:0] redun0_t;

  localparam int SEQ_TIMEOUT = 1024;
  localparam int SEQ_RST_CYC = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    FLUSH
  } seq_state_t;

endpackage

// File: rtl/redun_mont_seq.sv
// Job sequencer for redun_mont: launches one self-fed squaring chain, counts T results,
// holds the T-th product for the consumer, then flushes the core.
module redun_mont_seq
  import redun_mont_pkg::*;
#(
  parameter int T_W     = T_LEN,
  parameter int TIMEOUT = SEQ_TIMEOUT,
  parameter int RST_CYC = SEQ_RST_CYC
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  redun0_t        i_start,
  input  logic [T_W-1:0] i_t,
  input  logic           i_start_val,
  output logic           o_start_rdy,
  output redun0_t        o_sq,
  output logic           o_sq_val,
  output logic           o_mont_rst,
  input  redun0_t        i_mul,
  input  logic           i_mul_val,
  output redun0_t        o_res,
  output logic           o_res_val,
  input  logic           i_res_rdy,
  input  logic           i_abort,
  output logic [T_W-1:0] o_cnt,
  output logic           o_busy,
  output logic           o_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RST_CYC + 1);

  seq_state_t     state, state_nxt;
  redun0_t        start_q;
  logic [T_W-1:0] t_q;
  logic [T_W-1:0] cnt_inc;
  logic [WD_W-1:0] wdog;
  logic [RC_W-1:0] flush_cnt;
  logic [1:0]     rst_sync;
  logic           rst_n_int;
  logic           accept, step, capture, wd_fire;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign cnt_inc = o_cnt + T_W'(1);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      IDLE: if (i_start_val) begin
        accept    = 1'b1;
        state_nxt = (i_t == '0) ? DONE : LOAD;
      end
      LOAD: state_nxt = i_abort ? FLUSH : RUN;
      RUN: begin
        if (i_abort) begin
          state_nxt = FLUSH;
        end else if (i_mul_val) begin
          step = 1'b1;
          if (cnt_inc == t_q) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          wd_fire   = 1'b1;
          state_nxt = FLUSH;
        end
      end
      DONE: begin
        if (i_abort)        state_nxt = FLUSH;
        else if (i_res_rdy) state_nxt = (t_q == '0) ? IDLE : FLUSH;
      end
      FLUSH: if (flush_cnt == RC_W'(RST_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state     <= IDLE;
      t_q       <= '0;
      o_cnt     <= '0;
      o_res     <= '0;
      o_err     <= 1'b0;
      wdog      <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        t_q   <= i_t;
        o_cnt <= '0;
        o_err <= 1'b0;
        if (i_t == '0) o_res <= i_start;
      end
      if (step)    o_cnt <= cnt_inc;
      if (capture) o_res <= i_mul;
      if (wd_fire) o_err <= 1'b1;
      // Watchdog runs only while waiting for results; leaving LOAD clears it.
      wdog      <= (state == RUN && !i_mul_val) ? wdog + WD_W'(1) : '0;
      flush_cnt <= (state == FLUSH) ? flush_cnt + RC_W'(1) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) start_q <= i_start;
  end

  assign o_sq        = (state == LOAD) ? start_q : '0;
  assign o_sq_val    = (state == LOAD);
  assign o_mont_rst  = (state == FLUSH);
  assign o_res_val   = (state == DONE);
  assign o_start_rdy = (state == IDLE);
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_redun_mont_seq.sv
// Scoreboard bench for redun_mont_seq with a behavioural squaring core (identity
// Montgomery/redundant mapping, squaring mod a prime, one result every CORE_LAT cycles).
module tb_redun_mont_seq;
  import redun_mont_pkg::*;

  localparam int TW       = 16;
  localparam int CORE_LAT = 3;
  localparam longint PRIME = 64'd1000003;

  typedef struct {
    logic [63:0] res;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0;
  redun0_t start_v = '0, sq, mul = '0, res;
  logic [TW-1:0] t_v = '0, cnt;
  logic start_val = 1'b0, start_rdy, sq_val, mont_rst, mul_val = 1'b0;
  logic res_val, res_rdy = 1'b1, abort = 1'b0, busy, err;

  int checks = 0, errors = 0;
  exp_t sb[$];
  int sqv_cnt = 0, mrst_cnt = 0, resv_cnt = 0, mulv_cnt = 0;
  logic core_en = 1'b1, core_busy = 1'b0;
  redun0_t core_cur = '0;
  int core_lat = 0;

  redun_mont_seq #(.T_W(TW), .TIMEOUT(16), .RST_CYC(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v), .i_t(t_v),
    .i_start_val(start_val), .o_start_rdy(start_rdy), .o_sq(sq), .o_sq_val(sq_val),
    .o_mont_rst(mont_rst), .i_mul(mul), .i_mul_val(mul_val), .o_res(res),
    .o_res_val(res_val), .i_res_rdy(res_rdy), .i_abort(abort), .o_cnt(cnt),
    .o_busy(busy), .o_err(err)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic redun0_t sqm(redun0_t x);
    return (x * x) % PRIME;
  endfunction

  // Behavioural core: loads on o_sq_val, then feeds each product back into itself.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0; core_lat <= 0; mul_val <= 1'b0; mul <= '0; core_cur <= '0;
    end else if (mont_rst) begin
      core_busy <= 1'b0; core_lat <= 0; mul_val <= 1'b0;
    end else if (sq_val) begin
      core_busy <= 1'b1; core_cur <= sq; core_lat <= 0; mul_val <= 1'b0;
    end else if (core_busy && core_lat == CORE_LAT - 1) begin
      core_lat <= 0; core_cur <= sqm(core_cur); mul <= sqm(core_cur); mul_val <= core_en;
    end else begin
      if (core_busy) core_lat <= core_lat + 1;
      mul_val <= 1'b0;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sqv_cnt  += int'(sq_val);
    mrst_cnt += int'(mont_rst);
    resv_cnt += int'(res_val);
    mulv_cnt += int'(mul_val);
    if (rst_n && res_val && res_rdy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got %0d, expected no result", res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_value", res, e.res);
        check("result_count", 64'(cnt), 64'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(string name, int budget);
    int k = 0;
    while (!start_rdy && k < budget) begin tick(); k++; end
    if (!start_rdy) begin
      checks++; errors++;
      $display("FAIL %s: start_rdy still %0d after %0d cycles, expected 1", name, start_rdy, budget);
    end
  endtask

  task automatic start_job(redun0_t s, logic [TW-1:0] t, bit expect_res, logic [63:0] r);
    exp_t e;
    wait_idle("wait_ready", 5000);
    start_v = s; t_v = t; start_val = 1'b1;
    if (expect_res) begin
      e.res = r; e.cnt = t;
      sb.push_back(e);
    end
    tick();
    start_val = 1'b0;
  endtask

  task automatic clear_counts();
    sqv_cnt = 0; mrst_cnt = 0; resv_cnt = 0; mulv_cnt = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;
    logic [63:0] held;
    repeat (3) tick();
    check("rst_start_rdy", start_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    check("rst_outputs", {sq_val, mont_rst, res_val}, 0);

    // T=3 from 2: 2 -> 4 -> 16 -> 256
    clear_counts();
    start_job(64'd2, 16'd3, 1'b1, 64'd256);
    check("load_sq_val", sq_val, 1);
    check("load_sq", sq, 2);
    tick();
    check("run_sq_forced_zero", sq, 0);
    wait_idle("t3_idle", 200);
    check("t3_sq_val_cycles", sqv_cnt, 1);
    check("t3_flush_cycles", mrst_cnt, 8);

    // T=0: result is the start value one cycle after acceptance, no flush
    clear_counts();
    start_job(64'd5, 16'd0, 1'b1, 64'd5);
    check("t0_res_val", res_val, 1);
    check("t0_res", res, 5);
    tick();
    check("t0_ready_after_1", start_rdy, 1);
    check("t0_no_flush", mrst_cnt, 0);

    // Timeout with a silent core: o_err 16 cycles after LOAD exit, i.e. 17 edges after accept
    core_en = 1'b0;
    clear_counts();
    start_job(64'd2, 16'd5, 1'b0, 64'd0);
    k = 0;
    while (!err && k < 40) begin tick(); k++; end
    check("timeout_edges", k, 17);
    check("timeout_in_flush", mont_rst, 1);
    wait_idle("timeout_idle", 100);
    check("timeout_flush_cycles", mrst_cnt, 8);
    check("timeout_no_res_val", resv_cnt, 0);
    check("timeout_err_sticky", err, 1);
    core_en = 1'b1;

    // Abort at o_cnt=500 of a T=1000 job
    clear_counts();
    start_job(64'd2, 16'd1000, 1'b0, 64'd0);
    check("new_job_clears_err", err, 0);
    k = 0;
    while (cnt != 16'd500 && k < 4000) begin tick(); k++; end
    check("abort_reached_500", cnt, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_flush", mont_rst, 1);
    repeat (7) tick();
    check("abort_not_ready_8", start_rdy, 0);
    tick();
    check("abort_ready_9", start_rdy, 1);
    check("abort_cnt_frozen", cnt, 500);
    check("abort_no_res_val", resv_cnt, 0);
    start_job(64'd2, 16'd4, 1'b1, 64'd65536);
    wait_idle("t4_idle", 200);

    // Consumer stalls 50 cycles in DONE while the core keeps producing
    res_rdy = 1'b0;
    start_job(64'd2, 16'd3, 1'b1, 64'd256);
    k = 0;
    while (!res_val && k < 100) begin tick(); k++; end
    check("stall_res_val", res_val, 1);
    held = res;
    clear_counts();
    repeat (50) tick();
    check("stall_res_stable", res, held);
    check("stall_res_256", res, 256);
    check("stall_cnt_frozen", cnt, 3);
    check("stall_core_running", mulv_cnt > 10, 1);
    res_rdy = 1'b1;
    wait_idle("stall_idle", 100);

    // Async reset mid-RUN with the clock stopped
    start_job(64'd2, 16'd1000, 1'b0, 64'd0);
    repeat (20) tick();
    check("pre_reset_busy", busy, 1);
    @(negedge clk);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #3;
    check("areset_busy", busy, 0);
    check("areset_start_rdy", start_rdy, 1);
    check("areset_cnt", cnt, 0);
    check("areset_outputs", {sq_val, mont_rst, res_val, err}, 0);
    #20 rst_n = 1'b1;
    #5 clk_en = 1'b1;
    repeat (4) tick();
    start_job(64'd2, 16'd2, 1'b1, 64'd16);
    wait_idle("t2_idle", 200);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redun_mont_seq.md
# redun_mont_seq

Iteration sequencer for the `redun_mont` repeated-squaring core. It accepts a Montgomery-form start value and an iteration count T over a valid/ready handshake, launches the core with a single `i_val` pulse, and counts the core's self-fed `o_val` results. It captures the T-th product, holds it until the consumer accepts it, and then flushes the core. It sits between the host/VDF top level and `redun_mont`, and takes over the job-control role that the bench currently plays.

## Interface
- `T_W`, default `T_LEN` (package), width of the iteration count and progress counter.
- `TIMEOUT`, default 1024, maximum cycles between consecutive core results before a fault.
- `RST_CYC`, default 8, cycles `o_mont_rst` is held high during a flush.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  `redun0_t`  start value, Montgomery form, redundant.
- `i_t`  in  `T_W`  number of squarings.
- `i_start_val`  in  1  job request.
- `o_start_rdy`  out  1  sequencer is idle and accepts a job.
- `o_sq`  out  `redun0_t`  to core `i_sq`.
- `o_sq_val`  out  1  to core `i_val`.
- `o_mont_rst`  out  1  to core `i_rst`, active-high, synchronous to `i_clk`.
- `i_mul`  in  `redun0_t`  from core `o_mul`.
- `i_mul_val`  in  1  from core `o_val`.
- `o_res`  out  `redun0_t`  final value.
- `o_res_val`  out  1  result valid.
- `i_res_rdy`  in  1  consumer accepts the result.
- `i_abort`  in  1  cancel the running job.
- `o_cnt`  out  `T_W`  squarings completed in the current job.
- `o_busy`  out  1  state is not IDLE.
- `o_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, LOAD, RUN, DONE, FLUSH.
- IDLE: `o_start_rdy`=1. On `i_start_val`, latch `i_start` and `i_t`, clear `o_cnt` and `o_err`.
  - If `i_t`==0, load `o_res` with the start value and go to DONE.
  - Otherwise go to LOAD.
- LOAD: exactly one cycle. Drive `o_sq`=latched start and `o_sq_val`=1, then go to RUN. `o_sq` is forced to 0 whenever `o_sq_val`=0.
- RUN: each `i_mul_val` increments `o_cnt` (wrapping at 2^`T_W` is impossible because `o_cnt`≤T).
  - When the incremented count equals T, register `i_mul` into `o_res` and go to DONE.
  - A watchdog counter resets on LOAD exit and on every `i_mul_val`. If it reaches `TIMEOUT` with no result, set `o_err`=1 and go to FLUSH; no result is produced.
- DONE: `o_res_val`=1 and `o_res` is stable. On `i_res_rdy`, go to FLUSH if T>0, or to IDLE if T==0.
  - While the core keeps emitting results in DONE, they are ignored and `o_cnt` stays frozen at T.
- FLUSH: `o_mont_rst`=1 for `RST_CYC` cycles, then go to IDLE.
- `i_abort` in LOAD, RUN or DONE goes to FLUSH on the next cycle and drops `o_res_val`. `i_abort` in IDLE or FLUSH is ignored. Abort takes priority over a simultaneous final `i_mul_val` and over `i_res_rdy`.
- `i_start_val` outside IDLE is ignored. It is not queued.

## Timing
- Reset (async assert, sync deassert inside the block): state IDLE, all outputs 0 except `o_start_rdy`=1, `o_res`=0, `o_cnt`=0, `o_err`=0.
- Start accepted at edge N: `o_sq_val` is high for the cycle after edge N only.
- T-th `i_mul_val` sampled at edge M: `o_res_val`=1 from edge M (registered; visible in cycle M+1).
- T==0: `o_res_val`=1 the cycle after acceptance.
- Result handshake completes at the edge where `o_res_val`&`i_res_rdy`. `o_start_rdy` rises `RST_CYC`+1 cycles later (1 cycle for T==0).
- Timeout: `o_err` rises exactly `TIMEOUT` cycles after the last watchdog clear.

## Structure
- Add to `redun_mont_pkg`: the `seq_state_t` enum and the `TIMEOUT`/`RST_CYC` defaults. `redun0_t` and `T_LEN` are reused from the package.
- Single module, no sub-module. The watchdog is an inline counter.
- A top-level wrapper `redun_mont_top` instantiates `redun_mont_seq` plus `redun_mont`. The bench targets that wrapper.

## Test plan
- a=2 (`to_mont`), T=3 → `from_mont(from_redun(o_res))`=256, `o_cnt`=3, `o_sq_val` high for exactly 1 cycle.
- T=0, start=`to_mont(5)` → `o_res_val` the cycle after acceptance, `o_res`==start, `o_mont_rst` never asserted.
- Stub core that never asserts `o_val`, `TIMEOUT`=16 → `o_err`=1 exactly 16 cycles after LOAD, FLUSH for 8 cycles, no `o_res_val`.
- a=2, T=1000, `i_abort` at `o_cnt`=500 → FLUSH, `o_start_rdy`=1 after 9 cycles. A following T=4 job yields 2^16=65536.
- `i_res_rdy` held low for 50 cycles in DONE while the core keeps running → `o_res` stable, `o_cnt` stays 3, handshake completes on `i_res_rdy`.
- `i_rst_n` asserted mid-RUN with the clock stopped → outputs reach reset values immediately. After deassertion, a T=2 job gives 16.
